hazard_ctrl: RTL



---
 rtl/hazard_ctrl_pkg.sv | 33 +++
 rtl/hazard_detect.sv | 45 ++++
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard sequencer and its helpers.
//   - REG_IDX_W : architectural register index width (x0..x31)
//   - state_e   : sequencer state (RUN, DROP)
//   - reg_idx_t : register index type
// ---------------------------------------------------------------------------
`ifndef REG_IDX_W
`define REG_IDX_W 5
`endif

package hazard_ctrl_pkg;

  localparam int REG_IDX_W = `REG_IDX_W;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // RUN : normal operation
  // DROP: a redirect happened while a fetch was still outstanding; the next
  //       fetch data to return belongs to the old path and must be discarded.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } state_e;

  // True when an ID source register reads the value a producer will write.
  // x0 is hardwired to zero and never carries a dependency.
  function automatic logic src_depends(input logic used, input reg_idx_t src,
                                       input reg_idx_t dst);
    return used & (src == dst) & (dst != '0);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Purely combinational load-use detector: flags when the instruction in ID
//   reads a register that the load currently in EX will write.
//   Ports:
//     rs1_idx_id, rs2_idx_id : ID source indices
//     rs1_used_id, rs2_used_id : ID source read enables
//     rd_idx_ex  : EX destination index
//     wben_ex    : EX instruction writes rd
//     is_load_ex : EX instruction is a load
//     load_use   : one-bubble hazard required
// ---------------------------------------------------------------------------
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1_idx_id,
  input  logic [REG_IDX_W-1:0] rs2_idx_id,
  input  logic                 rs1_used_id,
  input  logic                 rs2_used_id,
  input  logic [REG_IDX_W-1:0] rd_idx_ex,
  input  logic                 wben_ex,
  input  logic                 is_load_ex,
  output logic                 load_use
);

  localparam int NUM_SRC = 2;

  reg_idx_t          src_idx  [NUM_SRC];
  logic [NUM_SRC-1:0] src_used;
  logic [NUM_SRC-1:0] src_hit;

  assign src_idx[0] = rs1_idx_id;
  assign src_idx[1] = rs2_idx_id;
  assign src_used   = {rs2_used_id, rs1_used_id};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_hit[gi] = src_depends(src_used[gi], src_idx[gi], rd_idx_ex);
    end
  endgenerate

  assign load_use = is_load_ex & wben_ex & (|src_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/LS/WB).
//   Causes, highest priority first: LS memory wait, taken jump in EX,
//   load-use between EX and ID, late instruction fetch. Tracks whether a fetch
//   outstanding across a redirect must be dropped, and counts stall cycles and
//   applied redirects in wrap-around counters.
//   Ports:
//     clk, rst                       : clock, synchronous active-high reset
//     rs1/rs2_idx_id, rs1/rs2_used_id: ID source operands
//     rd_idx_ex, wben_ex, is_load_ex : EX producer
//     is_jump_ex                     : taken redirect resolved in EX
//     dmem_req_ls, dmem_ready        : LS data-memory handshake
//     imem_valid                     : fetch data valid for current PC
//     stall_pc/id/ex/ls              : hold stage registers
//     flush_id/ex/wb                 : insert bubble into stage registers
//     fetch_drop                     : discard the returning fetch data
//     stall_cnt, flush_cnt           : performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int XLEN  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_idx_id,
  input  logic [REG_IDX_W-1:0] rs2_idx_id,
  input  logic                 rs1_used_id,
  input  logic                 rs2_used_id,
  input  logic [REG_IDX_W-1:0] rd_idx_ex,
  input  logic                 wben_ex,
  input  logic                 is_load_ex,
  input  logic                 is_jump_ex,
  input  logic                 dmem_req_ls,
  input  logic                 dmem_ready,
  input  logic                 imem_valid,
  output logic                 stall_pc,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_ls,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 flush_wb,
  output logic                 fetch_drop,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  // Elaboration-time sanity on parameters.
  generate
    if (CNT_W < 1 || XLEN < 32) begin : g_param_check
      $error("hazard_ctrl: unsupported CNT_W/XLEN");
    end
  endgenerate

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

  logic mem_busy;
  logic load_use;
  logic fetch_late;
  logic jump_apply;

  hazard_detect u_hazard_detect (
    .rs1_idx_id  (rs1_idx_id),
    .rs2_idx_id  (rs2_idx_id),
    .rs1_used_id (rs1_used_id),
    .rs2_used_id (rs2_used_id),
    .rd_idx_ex   (rd_idx_ex),
    .wben_ex     (wben_ex),
    .is_load_ex  (is_load_ex),
    .load_use    (load_use)
  );

  assign mem_busy = dmem_req_ls & ~dmem_ready;

  // In DROP, valid fetch data is stale, so it is no better than no data.
  assign fetch_late = ~imem_valid | (state_reg == ST_DROP);

  // A memory wait freezes EX, so the jump is re-presented once LS completes.
  assign jump_apply = is_jump_ex & ~mem_busy & ~rst;

  // Priority mux for stage controls; all quiet while in reset.
  always_comb begin
    stall_pc   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_ls   = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    flush_wb   = 1'b0;
    fetch_drop = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        stall_pc = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        stall_ls = 1'b1;
        flush_wb = 1'b1;
      end else if (is_jump_ex) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        // Single bubble: next cycle the load sits in LS and forwarding covers it.
        stall_pc = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end else if (fetch_late) begin
        stall_pc = 1'b1;
        flush_id = 1'b1;
      end
      fetch_drop = (state_reg == ST_DROP) & imem_valid;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        // Redirect with the old-path fetch still in flight.
        if (jump_apply & ~imem_valid) begin
          state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        // The one outstanding fetch has returned and been discarded. A new
        // jump meanwhile does not add another outstanding fetch.
        if (imem_valid) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Counters wrap naturally on overflow.
  always_comb begin
    stall_cnt_next = stall_cnt_reg + CNT_W'(stall_pc);
    flush_cnt_next = flush_cnt_reg + CNT_W'(jump_apply);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule
